// File: rtl/definitions.sv
// Shared types and sizing for the instruction-memory loader.
package definitions;

    // Default instruction word width (bits) and instruction address width.
    localparam int INST_MEM_SIZE  = 32;
    localparam int INST_MEM_DEPTH = 10;

    // Bytes needed to carry one instruction word, rounded up.
    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

    localparam int INST_BYTES = bytes_for(INST_MEM_SIZE);

    // Loader control states.
    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } LoaderState;

endpackage

// File: rtl/byte_word_assembler.sv
// Builds a little-endian instruction word from a byte stream: each pushed
// byte lands in the lane selected by the byte index, lane 0 first.
module byte_word_assembler #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              push,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word_out,
    output logic              full
);
    import definitions::*;

    localparam int NB    = bytes_for(WORD_W);
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    logic [NB*8-1:0]  word_q, word_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // full: the next pushed byte fills the top lane and completes the word.
    assign full     = (idx_q == LAST_IDX);
    // Bits of the top byte above WORD_W are dropped here.
    assign word_out = word_q[WORD_W-1:0];

    // Lane insert and byte index advance; load restarts an empty word.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load) begin
            word_d = '0;
            idx_d  = '0;
        end else if (push) begin
            word_d[int'(idx_q)*8 +: 8] = byte_in;
            idx_d = full ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Assembler storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Host-side instruction-memory writer: parses a length-prefixed byte frame,
// writes assembled words sequentially, checks a trailing XOR checksum and
// holds the controller in reset until a load succeeds.
module inst_loader #(
    parameter int INST_MEM_SIZE  = definitions::INST_MEM_SIZE,
    parameter int INST_MEM_DEPTH = definitions::INST_MEM_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_data,
    output logic                      byte_ready,
    input  logic                      clear,
    output logic [INST_MEM_SIZE-1:0]  inst_write_data,
    output logic [INST_MEM_DEPTH-1:0] inst_write_addr,
    output logic                      inst_write_enable,
    output logic                      core_reset,
    output logic                      done,
    output logic                      error
);
    import definitions::*;

    // One extra bit so the address can reach N == 2^INST_MEM_DEPTH
    // for the end-of-frame comparison without wrapping.
    localparam int CNT_W = INST_MEM_DEPTH + 1;

    LoaderState       state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [CNT_W-1:0] addr_q, addr_d;
    logic [7:0]       chk_q, chk_d;
    logic             we_q, we_d;
    logic             core_reset_q, core_reset_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic                     accept;
    logic                     asm_load;
    logic                     asm_push;
    logic                     asm_full;
    logic [INST_MEM_SIZE-1:0] asm_word;
    logic [31:0]              frame_len;
    logic                     last_word;

    // Stall only in the write cycle; nothing is accepted while in reset.
    assign byte_ready = reset_n && (state_q != WRITE);
    assign accept     = byte_valid && byte_ready;

    // Length as it would be once the byte on the bus is taken as LEN_HI.
    assign frame_len  = {16'd0, byte_data, len_q[7:0]};
    assign last_word  = ((32'(addr_q) + 32'd1) == {16'd0, len_q});

    byte_word_assembler #(
        .WORD_W (INST_MEM_SIZE)
    ) u_asm (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (asm_load),
        .push     (asm_push),
        .byte_in  (byte_data),
        .word_out (asm_word),
        .full     (asm_full)
    );

    // Next-state and registered-output decode; clear overrides any byte.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        addr_d       = addr_q;
        chk_d        = chk_q;
        we_d         = 1'b0;
        core_reset_d = core_reset_q;
        done_d       = done_q;
        error_d      = error_q;
        asm_load     = 1'b0;
        asm_push     = 1'b0;

        if (clear) begin
            state_d = IDLE;
            done_d  = 1'b0;
            error_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        len_d        = {8'h00, byte_data};
                        chk_d        = 8'h00;
                        asm_load     = 1'b1;
                        core_reset_d = 1'b1;
                        done_d       = 1'b0;
                        error_d      = 1'b0;
                        state_d      = LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len_d[15:8] = byte_data;
                        if (frame_len == 32'd0) begin
                            state_d = CHECK;
                        end else if (frame_len > (32'd1 << INST_MEM_DEPTH)) begin
                            error_d = 1'b1;
                            state_d = ERROR;
                        end else begin
                            addr_d  = '0;
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        asm_push = 1'b1;
                        chk_d    = chk_q ^ byte_data;
                        if (asm_full) begin
                            we_d    = 1'b1;
                            state_d = WRITE;
                        end
                    end
                end
                WRITE: begin
                    addr_d  = addr_q + CNT_W'(1);
                    state_d = last_word ? CHECK : DATA;
                end
                CHECK: begin
                    if (accept) begin
                        if (byte_data == chk_q) begin
                            done_d       = 1'b1;
                            core_reset_d = 1'b0;
                            state_d      = DONE;
                        end else begin
                            error_d = 1'b1;
                            state_d = ERROR;
                        end
                    end
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; reset holds the controller in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            addr_q       <= '0;
            chk_q        <= '0;
            we_q         <= 1'b0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            chk_q        <= chk_d;
            we_q         <= we_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign inst_write_enable = we_q;
    assign inst_write_addr   = addr_q[INST_MEM_DEPTH-1:0];
    assign inst_write_data   = asm_word;
    assign core_reset        = core_reset_q;
    assign done              = done_q;
    assign error             = error_q;

endmodule
